delta_calc_scheduler: RTL and testbench
=======================================

DELTA_CALC_SCHEDULER -- requirements
Module: delta_calc_scheduler

Interface
REQ-001 Parameter: NUM_CH, 4, number of wheel-steering requesters (fixed at 4 in this revision).
REQ-002 Parameter: TIMEOUT_CYC, 64, WAIT-state cycle limit before a calculation is abandoned.
REQ-003 Port: clock  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  per-channel level request; held until that channel's done or timeout_err pulse.
REQ-006 Port: target_angle_bus  input  48  channel i target angle at bits [12i+11:12i], 4096 points/rotation.
REQ-007 Port: current_angle_bus  input  48  channel i encoder angle at bits [12i+11:12i].
REQ-008 Port: calc_enable  output  1  enable to the shared delta-calculation datapath.
REQ-009 Port: calc_target, calc_current  output  12 each  operands to the shared datapath.
REQ-010 Port: calc_dir, calc_delta, calc_updated  input  1/12/1  shortest-path direction, shortest distance and completion pulse from the shared datapath.
REQ-011 Port: result_dir  output  4  latched direction per channel.
REQ-012 Port: result_delta  output  48  latched delta per channel, same packing as REQ-006.
REQ-013 Port: done  output  4  one-cycle pulse per channel on result update.
REQ-014 Port: timeout_err  output  4  one-cycle pulse per channel on abandoned calculation.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, WAIT, DONE; all outputs are registered.
REQ-017 IDLE, any req bit high at edge N: grant one channel round-robin; at edge N latch grant index, calc_target and calc_current from that channel's bus slices, set calc_enable=1, clear the timeout counter, and go to WAIT.
REQ-018 Round-robin: search starts at (last granted + 1) mod 4; after reset the search starts at channel 0.
REQ-019 Operands are frozen from grant until return to IDLE; bus changes during WAIT are ignored.
REQ-020 WAIT, calc_updated=1: at that edge write calc_dir and calc_delta into the granted channel's result slot, pulse done[grant], set calc_enable=0, and go to DONE.
REQ-021 WAIT, calc_updated=0: increment the timeout counter; when it reaches TIMEOUT_CYC-1, pulse timeout_err[grant], set calc_enable=0, leave results unchanged, and go to DONE.
REQ-022 calc_updated and timeout in the same cycle: calc_updated wins, with done and no timeout_err.
REQ-023 DONE: unconditionally go to IDLE; calc_enable is therefore low for at least 2 cycles between operations.
REQ-024 calc_updated is ignored outside WAIT.
REQ-025 req deasserted during WAIT does not abort: the result is still written and done is still pulsed.
REQ-026 req held high after done: the channel is re-arbitrated normally, behind the other pending channels.
REQ-027 Best-case latency from req sampled in IDLE to done pulse is 1 + datapath latency + 1 cycles.
REQ-028 At most one done or timeout_err bit is high in any cycle.

Reset
REQ-029 reset=1 at an edge forces IDLE, and clears calc_enable, calc_target, calc_current, result_dir, result_delta, done, timeout_err, busy, the timeout counter and the grant index, with the round-robin pointer set so channel 0 is searched first.
REQ-030 Reset mid-WAIT: calc_enable is low from the next edge; no done or timeout_err pulse is generated for the aborted operation.

Structure
REQ-031 Shared package holds NUM_CH, angle width (12), default TIMEOUT_CYC, and the state encoding constants.
REQ-032 The 4-way round-robin arbiter is a separate sub-module, rr_arbiter4, with req[3:0], pointer, and one-hot grant outputs; the shared delta datapath stays outside this block.

Verification
REQ-033 Single request: req=0001, target 200, current 100, datapath model returns dir=1, delta=100 after 3 cycles -> calc_target=200, calc_current=100, done=0001 for one cycle, result_delta[11:0]=100, result_dir[0]=1.
REQ-034 Round robin: req=1111 held, then each channel dropped on its own done -> grant order 0,1,2,3; next burst with req=1111 again starts at 0.
REQ-035 Wrap-around operands: channel 2 has target 4080, current 200; model returns delta=216, dir=0 -> result_delta[35:24]=216, result_dir[2]=0.
REQ-036 Timeout: req=0100 with calc_updated never asserted -> timeout_err=0100 exactly TIMEOUT_CYC cycles after calc_enable rises, result unchanged, busy low 2 cycles later.
REQ-037 Collision: calc_updated rises on the final timeout cycle -> done pulse, no timeout_err.
REQ-038 Reset mid-WAIT: reset asserted 2 cycles after grant -> next cycle calc_enable=0, busy=0, all results 0, and no done pulse afterwards.

Source files
------------

// File: rtl/delta_calc_scheduler_pkg.sv
// Shared constants and types for the delta-calculation scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package delta_calc_scheduler_pkg;

  localparam int NUM_CH          = 4;
  localparam int ANGLE_W         = 12;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the (single) set bit of a 4-bit one-hot vector; 0 when empty.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/delta_calc_scheduler_rr_arbiter4.sv
// 4-way round-robin arbiter: one-hot grant of the first requester at or after ptr_i.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req_i[3:0] requests, ptr_i search start channel, grant_o[3:0] one-hot grant (0 if no request).
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o
);

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [3:0] pick_rot;
  logic [7:0] pick_dbl;

  always_comb begin
    // Rotate so bit k of req_rot is channel (ptr+k) mod 4, take the lowest
    // set bit, then rotate the pick back into channel order.
    req_dbl  = {req_i, req_i};
    req_rot  = req_dbl[ptr_i +: 4];
    pick_rot = req_rot & (~req_rot + 4'd1);
    pick_dbl = {pick_rot, pick_rot} << ptr_i;
    grant_o  = pick_dbl[7:4];
  end

endmodule

// File: rtl/delta_calc_scheduler.sv
// Time-shares one delta-angle datapath among 4 steering channels, round-robin.
// Latency: grant 1 cycle after req, done/timeout_err 1 cycle after calc_updated (or TIMEOUT_CYC cycles), then 1 idle cycle.
// Backpressure: requesters hold req until their done/timeout_err pulse; one operation in flight at a time.
// Ports: clock_i/reset_i (sync, active-high); req_i, target/current angle buses (12 bits per channel);
//        calc_* handshake to the shared datapath; result_dir_o/result_delta_o latched per channel;
//        done_o/timeout_err_o one-cycle per-channel pulses; busy_o high outside IDLE.
module delta_calc_scheduler #(
  parameter int NUM_CH      = delta_calc_scheduler_pkg::NUM_CH,
  parameter int TIMEOUT_CYC = delta_calc_scheduler_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_CH-1:0]      req_i,
  input  logic [NUM_CH*12-1:0]   target_angle_bus_i,
  input  logic [NUM_CH*12-1:0]   current_angle_bus_i,
  output logic                   calc_enable_o,
  output logic [11:0]            calc_target_o,
  output logic [11:0]            calc_current_o,
  input  logic                   calc_dir_i,
  input  logic [11:0]            calc_delta_i,
  input  logic                   calc_updated_i,
  output logic [NUM_CH-1:0]      result_dir_o,
  output logic [NUM_CH*12-1:0]   result_delta_o,
  output logic [NUM_CH-1:0]      done_o,
  output logic [NUM_CH-1:0]      timeout_err_o,
  output logic                   busy_o
);

  import delta_calc_scheduler_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic [1:0]             grant_idx_q, grant_idx_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   calc_enable_q, calc_enable_d;
  logic [ANGLE_W-1:0]     calc_target_q, calc_target_d;
  logic [ANGLE_W-1:0]     calc_current_q, calc_current_d;
  logic [NUM_CH-1:0]      result_dir_q, result_dir_d;
  logic [NUM_CH*12-1:0]   result_delta_q, result_delta_d;
  logic [NUM_CH-1:0]      done_q, done_d;
  logic [NUM_CH-1:0]      timeout_err_q, timeout_err_d;
  logic [3:0]             arb_grant;

  rr_arbiter4 u_arb (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant)
  );

  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    rr_ptr_d       = rr_ptr_q;
    tmo_cnt_d      = tmo_cnt_q;
    calc_enable_d  = calc_enable_q;
    calc_target_d  = calc_target_q;
    calc_current_d = calc_current_q;
    result_dir_d   = result_dir_q;
    result_delta_d = result_delta_q;
    done_d         = '0;
    timeout_err_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_idx_d    = onehot4_to_idx(arb_grant);
          calc_target_d  = target_angle_bus_i[grant_idx_d*ANGLE_W +: ANGLE_W];
          calc_current_d = current_angle_bus_i[grant_idx_d*ANGLE_W +: ANGLE_W];
          rr_ptr_d       = grant_idx_d + 2'd1;
          calc_enable_d  = 1'b1;
          tmo_cnt_d      = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion on the last timeout cycle takes precedence.
        if (calc_updated_i) begin
          result_dir_d[grant_idx_q]                          = calc_dir_i;
          result_delta_d[grant_idx_q*ANGLE_W +: ANGLE_W]     = calc_delta_i;
          done_d[grant_idx_q]                                = 1'b1;
          calc_enable_d                                      = 1'b0;
          state_d                                            = ST_DONE;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d[grant_idx_q] = 1'b1;
          calc_enable_d              = 1'b0;
          state_d                    = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        calc_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      grant_idx_q    <= '0;
      rr_ptr_q       <= '0;
      tmo_cnt_q      <= '0;
      calc_enable_q  <= 1'b0;
      calc_target_q  <= '0;
      calc_current_q <= '0;
      result_dir_q   <= '0;
      result_delta_q <= '0;
      done_q         <= '0;
      timeout_err_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      calc_enable_q  <= calc_enable_d;
      calc_target_q  <= calc_target_d;
      calc_current_q <= calc_current_d;
      result_dir_q   <= result_dir_d;
      result_delta_q <= result_delta_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign calc_enable_o  = calc_enable_q;
  assign calc_target_o  = calc_target_q;
  assign calc_current_o = calc_current_q;
  assign result_dir_o   = result_dir_q;
  assign result_delta_o = result_delta_q;
  assign done_o         = done_q;
  assign timeout_err_o  = timeout_err_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_delta_calc_scheduler.sv
// Self-checking bench for delta_calc_scheduler with a behavioural datapath and scheduler model.
module tb_delta_calc_scheduler;

  localparam int TMO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] tgt [4];
  logic [11:0] cur [4];
  logic [47:0] target_bus, current_bus;
  logic        calc_dir;
  logic [11:0] calc_delta;
  logic        calc_updated;

  logic        calc_enable;
  logic [11:0] calc_target, calc_current;
  logic [3:0]  result_dir;
  logic [47:0] result_delta;
  logic [3:0]  done, timeout_err;
  logic        busy;

  assign target_bus  = {tgt[3], tgt[2], tgt[1], tgt[0]};
  assign current_bus = {cur[3], cur[2], cur[1], cur[0]};

  always #5 clock = ~clock;

  delta_calc_scheduler #(.NUM_CH(4), .TIMEOUT_CYC(TMO)) dut (
    .clock_i             (clock),
    .reset_i             (reset),
    .req_i               (req),
    .target_angle_bus_i  (target_bus),
    .current_angle_bus_i (current_bus),
    .calc_enable_o       (calc_enable),
    .calc_target_o       (calc_target),
    .calc_current_o      (calc_current),
    .calc_dir_i          (calc_dir),
    .calc_delta_i        (calc_delta),
    .calc_updated_i      (calc_updated),
    .result_dir_o        (result_dir),
    .result_delta_o      (result_delta),
    .done_o              (done),
    .timeout_err_o       (timeout_err),
    .busy_o              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: next channel searched first, and latched results.
  int          ref_ptr;
  logic [47:0] exp_delta;
  logic [3:0]  exp_dir;
  int          grant_log[$];
  int          last_wait;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Shortest path on a 4096-point circle: {dir, delta}, dir=1 for increasing angle.
  function automatic logic [12:0] shortest(input logic [11:0] t, input logic [11:0] c);
    int d;
    d = (int'(t) - int'(c) + 4096) % 4096;
    if (d <= 2048) return {1'b1, 12'(d)};
    return {1'b0, 12'(4096 - d)};
  endfunction

  task automatic model_reset();
    ref_ptr   = 0;
    exp_delta = '0;
    exp_dir   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_angles();
    for (int k = 0; k < 4; k++) begin
      tgt[k] = 12'($urandom);
      cur[k] = 12'($urandom);
    end
  endtask

  // Wait for the predicted grant, answer after lat cycles, check the result.
  task automatic serve(input int lat, input bit drop, input bit scramble);
    int          g, obs, waited;
    logic [11:0] t, c;
    logic [12:0] r;
    logic [3:0]  exp_oh;
    g = rr_pick(req, ref_ptr);
    waited = 0;
    while (calc_enable !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    last_wait = waited;
    n_checks++;
    if (calc_enable !== 1'b1 || g < 0) begin
      n_fail++;
      $display("FAIL serve_grant: calc_enable=%b req=%b, required a grant within 8 cycles", calc_enable, req);
      return;
    end
    t = tgt[g];
    c = cur[g];
    r = shortest(t, c);
    n_checks++;
    if (calc_target !== t || calc_current !== c) begin
      n_fail++;
      $display("FAIL serve_operands ch%0d: got %0d/%0d, required %0d/%0d", g, calc_target, calc_current, t, c);
    end
    if (scramble) rand_angles();
    repeat (lat - 1) @(negedge clock);
    calc_updated = 1'b1;
    calc_dir     = r[12];
    calc_delta   = r[11:0];
    @(negedge clock);
    calc_updated = 1'b0;
    calc_dir     = 1'($urandom);
    calc_delta   = 12'($urandom);
    exp_dir[g]           = r[12];
    exp_delta[g*12 +: 12] = r[11:0];
    ref_ptr = (g + 1) % 4;
    exp_oh  = 4'(1 << g);
    if (drop) req[g] = 1'b0;
    obs = -1;
    for (int k = 0; k < 4; k++) if (done[k] === 1'b1) obs = k;
    grant_log.push_back(obs);
    n_checks++;
    if (done !== exp_oh || timeout_err !== 4'b0000) begin
      n_fail++;
      $display("FAIL serve_done: done=%b timeout_err=%b, required done=%b timeout_err=0000", done, timeout_err, exp_oh);
    end
    n_checks++;
    if (result_delta !== exp_delta || result_dir !== exp_dir) begin
      n_fail++;
      $display("FAIL serve_result: delta=%h dir=%b, required delta=%h dir=%b", result_delta, result_dir, exp_delta, exp_dir);
    end
    n_checks++;
    if (calc_enable !== 1'b0 || calc_target !== t || calc_current !== c) begin
      n_fail++;
      $display("FAIL serve_frozen: en=%b tgt=%0d cur=%0d, required en=0 tgt=%0d cur=%0d", calc_enable, calc_target, calc_current, t, c);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 4'b0000) begin
      n_fail++;
      $display("FAIL serve_pulse_width: done=%b, required 0000", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    rand_angles();
    repeat (2) @(negedge clock);
    n_checks++;
    if (calc_enable !== 1'b0 || busy !== 1'b0 || done !== 4'b0 || timeout_err !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%b busy=%b done=%b terr=%b, required all 0", calc_enable, busy, done, timeout_err);
    end
    n_checks++;
    if (calc_target !== 12'd0 || calc_current !== 12'd0 || result_delta !== 48'd0 || result_dir !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: tgt=%0d cur=%0d delta=%h dir=%b, required all 0", calc_target, calc_current, result_delta, result_dir);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    tgt[0] = 12'd200;
    cur[0] = 12'd100;
    req = 4'b0001;
    serve(3, 1, 0);
    n_checks++;
    if (last_wait !== 1) begin
      n_fail++;
      $display("FAIL single_grant_latency: %0d cycles, required 1", last_wait);
    end
    n_checks++;
    if (result_delta[11:0] !== 12'd100 || result_dir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: delta=%0d dir=%b, required 100/1", result_delta[11:0], result_dir[0]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    rand_angles();
    grant_log.delete();
    req = 4'b1111;
    repeat (4) serve(int'($urandom_range(1, 5)), 1, 0);
    req = 4'b1111;
    serve(int'($urandom_range(1, 5)), 1, 0);
    repeat (3) serve(int'($urandom_range(1, 5)), 1, 0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= grant_log.size() || grant_log[i] !== (i % 4)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, i % 4);
      end
    end
  endtask

  task automatic test_wrap();
    tgt[2] = 12'd4080;
    cur[2] = 12'd200;
    req = 4'b0100;
    serve(2, 1, 0);
    n_checks++;
    if (result_delta[35:24] !== 12'd216 || result_dir[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_result: delta=%0d dir=%b, required 216/0", result_delta[35:24], result_dir[2]);
    end
  endtask

  task automatic test_timeout();
    int waited, cnt;
    bit early_done;
    tgt[2] = 12'($urandom);
    req = 4'b0100;
    waited = 0;
    while (calc_enable !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    cnt = 0;
    early_done = 1'b0;
    while (timeout_err === 4'b0000 && cnt < TMO + 8) begin
      @(negedge clock);
      cnt++;
      if (done !== 4'b0000) early_done = 1'b1;
    end
    n_checks++;
    if (cnt !== TMO || timeout_err !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_timing: terr=%b after %0d cycles, required 0100 after %0d", timeout_err, cnt, TMO);
    end
    n_checks++;
    if (early_done || calc_enable !== 1'b0 || result_delta !== exp_delta || result_dir !== exp_dir) begin
      n_fail++;
      $display("FAIL timeout_state: done_seen=%0d en=%b delta=%h dir=%b, required 0/0/%h/%b", early_done, calc_enable, result_delta, result_dir, exp_delta, exp_dir);
    end
    req = 4'b0000;
    ref_ptr = 3;
    @(negedge clock);
    n_checks++;
    if (timeout_err !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: terr=%b, required 0000", timeout_err);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_collision();
    tgt[2] = 12'($urandom);
    cur[2] = 12'($urandom);
    req = 4'b0100;
    serve(TMO, 1, 0);
  endtask

  task automatic test_req_held();
    do_reset();
    rand_angles();
    grant_log.delete();
    req = 4'b0011;
    repeat (3) serve(2, 0, 0);
    req = 4'b0000;
    n_checks++;
    if (grant_log.size() != 3 || grant_log[0] !== 0 || grant_log[1] !== 1 || grant_log[2] !== 0) begin
      n_fail++;
      $display("FAIL req_held_order: got %p, required '{0,1,0}", grant_log);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      rand_angles();
      req = 4'($urandom_range(1, 15));
      serve(int'($urandom_range(1, 6)), 1, 1);
    end
    req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_ignore_outside_wait();
    req = 4'b0000;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      calc_updated = 1'b1;
      calc_dir     = 1'b1;
      calc_delta   = 12'hABC;
      @(negedge clock);
      n_checks++;
      if (done !== 4'b0 || busy !== 1'b0 || result_delta !== exp_delta || result_dir !== exp_dir) begin
        n_fail++;
        $display("FAIL ignore_idle[%0d]: done=%b busy=%b delta=%h dir=%b, required 0000/0/%h/%b", i, done, busy, result_delta, result_dir, exp_delta, exp_dir);
      end
    end
    calc_updated = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int waited;
    req = 4'b0001;
    waited = 0;
    while (calc_enable !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = 4'b0000;
    model_reset();
    n_checks++;
    if (calc_enable !== 1'b0 || busy !== 1'b0 || result_delta !== 48'd0 || result_dir !== 4'd0) begin
      n_fail++;
      $display("FAIL midwait_reset: en=%b busy=%b delta=%h dir=%b, required 0/0/0/0", calc_enable, busy, result_delta, result_dir);
    end
    calc_updated = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      calc_updated = 1'b0;
      n_checks++;
      if (done !== 4'b0 || timeout_err !== 4'b0) begin
        n_fail++;
        $display("FAIL midwait_no_pulse[%0d]: done=%b terr=%b, required 0000/0000", i, done, timeout_err);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    req          = '0;
    calc_updated = 1'b0;
    calc_dir     = 1'b0;
    calc_delta   = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_collision();
    test_req_held();
    test_back_to_back();
    test_ignore_outside_wait();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
